// File: rtl/gate_sweep_checker_pkg.sv
// gate_sweep_pkg
//   Shared definitions for the gate sweep checker: gate vector type, FSM state
//   encoding, the golden truth table and a popcount helper. The golden table
//   is also available to any testbench that wants it.
package gate_sweep_pkg;

    localparam int NUM_GATES = 7;

    // Bit order, MSB first: {not, and, or, nand, nor, xor, xnor}
    typedef logic [NUM_GATES-1:0] gate_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Golden response of the two-input basic gate block. "not" acts on A only.
    function automatic gate_vec_t expected_vec(input logic a, input logic b);
        return {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    function automatic logic [2:0] popcount7(input gate_vec_t v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_GATES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if
//   Connection between the sweep checker and the gate block under test.
//   master : checker side, drives A/B and observes the seven gate outputs.
//   slave  : gate block side, receives A/B and returns the gate outputs.
interface gate_sweep_checker_if;
    logic drive_a;
    logic drive_b;
    logic y_not;
    logic y_and;
    logic y_or;
    logic y_nand;
    logic y_nor;
    logic y_xor;
    logic y_xnor;

    modport master (
        output drive_a, drive_b,
        input  y_not, y_and, y_or, y_nand, y_nor, y_xor, y_xnor
    );

    modport slave (
        input  drive_a, drive_b,
        output y_not, y_and, y_or, y_nand, y_nor, y_xor, y_xnor
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Sweeps {A,B} through 00,01,10,11 on the gate block, holds each pattern for
//   SETTLE_CYCLES cycles, then samples the seven gate outputs and compares
//   them with the golden table.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : sweep request, honoured only in IDLE
//   gate        : A/B drive and gate outputs (interface, master side)
//   busy        : sweep in progress (cycle after accept .. last SAMPLE cycle)
//   done        : one-cycle pulse when results are valid
//   pass        : last sweep had no mismatches
//   err_count   : saturating count of mismatching output bits in last sweep
//   fail_vec    : bit i set if combination {A,B}=i had any mismatch
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    gate_sweep_checker_if.master gate,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [3:0]           fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Enough headroom to add up to 7 mismatches before saturating.
    localparam int SUM_W = ERR_CNT_W + 3;
    localparam logic [SUM_W-1:0] ERR_MAX = {3'b000, {ERR_CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 drive_a_q, drive_a_d;
    logic                 drive_b_q, drive_b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [3:0]           fail_vec_q, fail_vec_d;

    gate_vec_t            observed;
    gate_vec_t            golden;
    gate_vec_t            diff;
    logic [SUM_W-1:0]     err_sum;
    logic [ERR_CNT_W-1:0] err_sat;

    // Comparator: golden vector follows idx, which always matches the drive.
    always_comb begin
        observed = {gate.y_not, gate.y_and, gate.y_or, gate.y_nand,
                    gate.y_nor, gate.y_xor, gate.y_xnor};
        golden   = expected_vec(idx_q[1], idx_q[0]);
        diff     = observed ^ golden;
        err_sum  = {3'b000, err_count_q} + SUM_W'(popcount7(diff));
        err_sat  = (err_sum > ERR_MAX) ? ERR_MAX[ERR_CNT_W-1:0]
                                       : err_sum[ERR_CNT_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        drive_a_d   = drive_a_q;
        drive_b_d   = drive_b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_vec_d  = fail_vec_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = 2'd0;
                    drive_a_d   = 1'b0;
                    drive_b_d   = 1'b0;
                    err_count_d = '0;
                    fail_vec_d  = 4'b0000;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = SETTLE;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                err_count_d       = err_sat;
                fail_vec_d[idx_q] = |diff;
                if (idx_q != 2'd3) begin
                    idx_d     = idx_q + 2'd1;
                    drive_a_d = idx_d[1];
                    drive_b_d = idx_d[0];
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end else begin
                    drive_a_d = 1'b0;
                    drive_b_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    // Saturation never wraps, so "no errors before and none
                    // now" is the same as the updated count being zero.
                    pass_d    = (err_count_q == '0) && (diff == '0);
                    state_d   = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            drive_a_q   <= 1'b0;
            drive_b_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fail_vec_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            drive_a_q   <= drive_a_d;
            drive_b_q   <= drive_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign gate.drive_a = drive_a_q;
    assign gate.drive_b = drive_b_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign fail_vec     = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker. Three instances share clk/rst_n/start:
//   u0 defaults, u1 with ERR_CNT_W=3, u2 with SETTLE_CYCLES=1.
// Each is wired to its own behavioural gate block with a selectable fault.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   fault;

    always #5 clk = ~clk;

    gate_sweep_checker_if bus0();
    gate_sweep_checker_if bus1();
    gate_sweep_checker_if bus2();

    logic       busy0, done0, pass0;
    logic [3:0] err0, fv0;
    logic       busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fv1;
    logic       busy2, done2, pass2;
    logic [3:0] err2, fv2;

    // Behavioural gate block; order {not,and,or,nand,nor,xor,xnor}.
    // fault: 0 good, 1 xor stuck-0, 2 all stuck-0, 3 and stuck-1.
    function automatic logic [6:0] gmodel(input int f, input logic a, input logic b);
        logic [6:0] v;
        v = {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        case (f)
            1: v[1] = 1'b0;
            2: v = 7'd0;
            3: v[5] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    assign {bus0.y_not, bus0.y_and, bus0.y_or, bus0.y_nand, bus0.y_nor, bus0.y_xor, bus0.y_xnor}
        = gmodel(fault, bus0.drive_a, bus0.drive_b);
    assign {bus1.y_not, bus1.y_and, bus1.y_or, bus1.y_nand, bus1.y_nor, bus1.y_xor, bus1.y_xnor}
        = gmodel(fault, bus1.drive_a, bus1.drive_b);
    assign {bus2.y_not, bus2.y_and, bus2.y_or, bus2.y_nand, bus2.y_nor, bus2.y_xor, bus2.y_xnor}
        = gmodel(fault, bus2.drive_a, bus2.drive_b);

    gate_sweep_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
    );
    gate_sweep_checker #(.ERR_CNT_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
    );
    gate_sweep_checker #(.SETTLE_CYCLES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int dcyc[3];
    int dcnt[3];
    bit seq_ok;

    // Pulse start, then observe cycles 0..19 after the accept edge at each
    // negedge. restart_at >= 0 raises start again during that cycle.
    task automatic sweep(input int restart_at);
        logic [1:0] exp_ab;
        logic       exp_busy;
        seq_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dcyc[i] = -1;
            dcnt[i] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (done0) begin dcnt[0]++; dcyc[0] = k; end
            if (done1) begin dcnt[1]++; dcyc[1] = k; end
            if (done2) begin dcnt[2]++; dcyc[2] = k; end
            exp_ab   = (k < 12) ? 2'(k / 3) : 2'd0;
            exp_busy = (k < 12);
            if ({bus0.drive_a, bus0.drive_b} != exp_ab || busy0 != exp_busy)
                seq_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int         f;
        int         exp_err;
        int         exp_err3;
        logic [3:0] exp_fv;
        logic       exp_pass;
    } vec_t;

    vec_t vecs[4];
    int   ndone;

    initial begin
        vecs[0] = '{f: 0, exp_err: 0,  exp_err3: 0, exp_fv: 4'b0000, exp_pass: 1'b1};
        vecs[1] = '{f: 1, exp_err: 2,  exp_err3: 2, exp_fv: 4'b0110, exp_pass: 1'b0};
        vecs[2] = '{f: 2, exp_err: 14, exp_err3: 7, exp_fv: 4'b1111, exp_pass: 1'b0};
        vecs[3] = '{f: 3, exp_err: 3,  exp_err3: 3, exp_fv: 4'b0111, exp_pass: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        fault = 0;
        #12;
        check("reset_outputs_u0", int'({busy0, done0, pass0, err0, fv0, bus0.drive_a, bus0.drive_b}), 0);
        check("reset_outputs_u1", int'({busy1, done1, pass1, err1, fv1, bus1.drive_a, bus1.drive_b}), 0);
        check("reset_outputs_u2", int'({busy2, done2, pass2, err2, fv2, bus2.drive_a, bus2.drive_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            fault = vecs[v].f;
            sweep(-1);
            check($sformatf("v%0d_done_cycle_u0", v), dcyc[0], 12);
            check($sformatf("v%0d_done_cycle_u1", v), dcyc[1], 12);
            check($sformatf("v%0d_done_cycle_u2", v), dcyc[2], 8);
            check($sformatf("v%0d_done_pulses", v), dcnt[0] + dcnt[1] + dcnt[2], 3);
            check($sformatf("v%0d_drive_busy_seq", v), int'(seq_ok), 1);
            check($sformatf("v%0d_pass_u0", v), int'(pass0), int'(vecs[v].exp_pass));
            check($sformatf("v%0d_err_u0", v), int'(err0), vecs[v].exp_err);
            check($sformatf("v%0d_fv_u0", v), int'(fv0), int'(vecs[v].exp_fv));
            check($sformatf("v%0d_pass_u1", v), int'(pass1), int'(vecs[v].exp_pass));
            check($sformatf("v%0d_err_u1", v), int'(err1), vecs[v].exp_err3);
            check($sformatf("v%0d_fv_u1", v), int'(fv1), int'(vecs[v].exp_fv));
            check($sformatf("v%0d_pass_u2", v), int'(pass2), int'(vecs[v].exp_pass));
            check($sformatf("v%0d_err_u2", v), int'(err2), vecs[v].exp_err);
            check($sformatf("v%0d_fv_u2", v), int'(fv2), int'(vecs[v].exp_fv));
        end

        // Results hold while idle.
        repeat (3) @(negedge clk);
        check("hold_err_u0", int'(err0), 3);
        check("hold_fv_u0", int'(fv0), 4'b0111);

        // Restart during a run is ignored; a fresh start clears old failures.
        fault = 1;
        sweep(-1);
        check("pre_restart_fv_u0", int'(fv0), 4'b0110);
        fault = 0;
        sweep(5);
        check("restart_done_cycle_u0", dcyc[0], 12);
        check("restart_done_pulses_u0", dcnt[0], 1);
        check("restart_seq_u0", int'(seq_ok), 1);
        check("restart_pass_u0", int'(pass0), 1);
        check("restart_err_u0", int'(err0), 0);
        check("restart_fv_u0", int'(fv0), 0);

        // Reset mid-run at cycle 4 (u0 is driving 01 and busy).
        fault = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy_u0", int'(busy0), 1);
        check("midrun_drive_u0", int'({bus0.drive_a, bus0.drive_b}), 1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_u0", int'({busy0, done0, pass0, err0, fv0, bus0.drive_a, bus0.drive_b}), 0);
        check("midrun_reset_u1", int'({busy1, done1, pass1, err1, fv1, bus1.drive_a, bus1.drive_b}), 0);
        check("midrun_reset_u2", int'({busy2, done2, pass2, err2, fv2, bus2.drive_a, bus2.drive_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            ndone += int'(done0) + int'(done1) + int'(done2) + int'(busy0);
        end
        check("no_done_after_reset", ndone, 0);

        // Fresh sweep after reset.
        fault = 0;
        sweep(-1);
        check("post_reset_done_cycle_u2", dcyc[2], 8);
        check("post_reset_done_cycle_u0", dcyc[0], 12);
        check("post_reset_pass_u2", int'(pass2), 1);
        check("post_reset_pass_u0", int'(pass0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around the two-input basic gate block.
- Upstream side: drives the gate block's A/B inputs through all four combinations in the order 00, 01, 10, 11, holding each for a programmable settle time.
- Downstream side: samples the seven gate outputs, compares them against a golden truth table and reports pass/fail, a mismatch count and a per-combination failure map.
- Lets the lab gate experiments run as synthesizable hardware checks, not only in simulation.

Parameters:
- SETTLE_CYCLES, 2: cycles each combination is held before sampling; legal range >= 1.
- ERR_CNT_W, 4: width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; accepted only in IDLE.
- drive_a  out  1  A input to the gate block.
- drive_b  out  1  B input to the gate block.
- y_not  in  1  gate block output, expected ~A.
- y_and  in  1  gate block output, expected A&B.
- y_or  in  1  gate block output, expected A|B.
- y_nand  in  1  gate block output, expected ~(A&B).
- y_nor  in  1  gate block output, expected ~(A|B).
- y_xor  in  1  gate block output, expected A^B.
- y_xnor  in  1  gate block output, expected ~(A^B).
- busy  out  1  high from the cycle after start is accepted through the last SAMPLE cycle.
- done  out  1  one-cycle pulse when results become valid.
- pass  out  1  1 when the last sweep had zero mismatches.
- err_count  out  ERR_CNT_W  saturating count of mismatching output bits in the last sweep.
- fail_vec  out  4  bit i set if combination i ({A,B}=i) had any mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE; drive_a=drive_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0, settle counter=0. All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 at an edge:
  - idx<=0; drive_a/drive_b <= 0/0.
  - err_count<=0, fail_vec<=0, pass<=0, busy<=1.
  - cnt<=0; go SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go SAMPLE; otherwise stay in SETTLE.
  - Drive outputs are held constant.
- SAMPLE (sampling edge):
  - Observed vector = {y_not,y_and,y_or,y_nand,y_nor,y_xor,y_xnor}.
  - XOR it with the expected vector for idx.
  - err_count += popcount(diff), saturating at 2^ERR_CNT_W-1.
  - fail_vec[idx] <= |diff.
  - If idx<3: idx++, drive <= new idx ({drive_a,drive_b}=idx), cnt<=0, go SETTLE.
  - If idx==3: go DONE, drive<=00, busy<=0, done<=1, and pass <= (err_count==0 && diff==0). Pass must use the post-update error count.
- DONE: lasts one cycle; done<=0; go IDLE.
- Results hold until the next accepted start.
- Timing: each combination takes SETTLE_CYCLES+1 cycles. Numbering the cycle after the accept edge as cycle 0, done is high in cycle 4*(SETTLE_CYCLES+1). With the default SETTLE_CYCLES=2, that is cycle 12.
- start in SETTLE, SAMPLE or DONE is ignored; it is not queued. start held high continuously re-triggers only from IDLE.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse; partial results discarded.
- Inputs are assumed synchronous to clk; no synchronizers.

Decomposition:
- Package gate_sweep_pkg holds:
  - constant NUM_GATES=7;
  - typedef gate_vec_t logic[6:0];
  - enum state_t {IDLE, SETTLE, SAMPLE, DONE};
  - function expected_vec(a,b) returning the golden vector, shared with the bench scoreboard.
- No sub-module; counter, FSM and comparator stay in one module.

Test Plan:
- Correct gate model, SETTLE_CYCLES=2, start pulse -> drive sequence 00,01,10,11 with 3 cycles each; done at cycle 12; pass=1, err_count=0, fail_vec=0000.
- y_xor stuck at 0 -> mismatches at combinations 01 and 10; err_count=2, fail_vec=0110, pass=0.
- All seven outputs stuck at 0 -> err_count=14, fail_vec=1111, pass=0. With ERR_CNT_W=3 -> err_count saturates at 7.
- start pulsed again at cycle 5 of a run -> ignored; done still at cycle 12, exactly one pulse. A subsequent start in IDLE clears the previous failing results.
- rst_n low at cycle 4 of a run -> all outputs 0 immediately, no done. SETTLE_CYCLES=1 run after reset -> done at cycle 8.
